// File: rtl/ycr_arb_rr.sv
// ycr_arb_rr
// Round-robin arbiter with registered grant outputs. A grant is held until the
// granted target acks, or optionally until a hold timeout expires.
//
// Parameters:
//   NREQ   - number of requesters (2..16)
//   IDW    - width of the grant index
//   TO_CYC - ack timeout in cycles (0 disables the timeout)
//   B2B    - 1: an ack immediately re-arbitrates among eligible requesters
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   req      - per-requester request levels
//   req_mask - per-requester enable (1 = eligible)
//   ack      - completion from the granted target
//   gnt_vld  - a grant is active
//   gnt_oh   - one-hot grant, all-zero when gnt_vld = 0
//   gnt_id   - index of the current grant, or of the last one when idle
//   to_pulse - one-cycle flag: grant was force-released by timeout
module ycr_arb_rr #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = $clog2(NREQ),
    parameter int unsigned TO_CYC = 0,
    parameter int unsigned B2B    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_mask,
    input  logic            ack,
    output logic            gnt_vld,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_id,
    output logic            to_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value on which the next un-acked edge releases the grant.
    localparam logic [7:0] TO_LAST = 8'((TO_CYC == 0) ? 0 : TO_CYC - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [7:0]      cnt, cnt_nxt;

    logic            gnt_vld_nxt;
    logic [NREQ-1:0] gnt_oh_nxt;
    logic [IDW-1:0]  gnt_id_nxt;
    logic            to_pulse_nxt;

    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_ptr;

    assign elig = req & req_mask;

    // Search upward from ptr with wrap; the first eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned idx;
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && elig[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
        win_oh  = NREQ'(1) << win_id;
        win_ptr = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        gnt_vld_nxt  = gnt_vld;
        gnt_oh_nxt   = gnt_oh;
        gnt_id_nxt   = gnt_id;
        to_pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt   = BUSY;
                    gnt_vld_nxt = 1'b1;
                    gnt_oh_nxt  = win_oh;
                    gnt_id_nxt  = win_id;
                    ptr_nxt     = win_ptr;
                    cnt_nxt     = '0;
                end
            end
            BUSY: begin
                // ack outranks a coinciding timeout; gnt_id parks on release.
                if (ack) begin
                    if ((B2B != 0) && win_found) begin
                        gnt_oh_nxt = win_oh;
                        gnt_id_nxt = win_id;
                        ptr_nxt    = win_ptr;
                        cnt_nxt    = '0;
                    end else begin
                        state_nxt   = IDLE;
                        gnt_vld_nxt = 1'b0;
                        gnt_oh_nxt  = '0;
                    end
                end else if ((TO_CYC != 0) && (cnt == TO_LAST)) begin
                    state_nxt    = IDLE;
                    gnt_vld_nxt  = 1'b0;
                    gnt_oh_nxt   = '0;
                    to_pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                gnt_vld_nxt = 1'b0;
                gnt_oh_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_oh   <= '0;
            gnt_id   <= '0;
            to_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            gnt_vld  <= gnt_vld_nxt;
            gnt_oh   <= gnt_oh_nxt;
            gnt_id   <= gnt_id_nxt;
            to_pulse <= to_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_ycr_arb_rr.sv
// Testbench for ycr_arb_rr. Four instances share the same stimulus:
//   cfg 0: TO_CYC=0, B2B=0   cfg 1: TO_CYC=0, B2B=1
//   cfg 2: TO_CYC=4, B2B=0   cfg 3: TO_CYC=4, B2B=1
// Every cycle each instance is compared against a reference model; directed
// scenarios add explicit expected values on top.
module tb_ycr_arb_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_mask;
    logic       ack;

    logic       gv  [4];
    logic [3:0] goh [4];
    logic [1:0] gid [4];
    logic       tp  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ycr_arb_rr #(
            .NREQ  (4),
            .IDW   (2),
            .TO_CYC((g >= 2) ? 4 : 0),
            .B2B   (g % 2)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .req_mask(req_mask),
            .ack     (ack),
            .gnt_vld (gv[g]),
            .gnt_oh  (goh[g]),
            .gnt_id  (gid[g]),
            .to_pulse(tp[g])
        );
    end

    // Reference model: per config, whether a grant is held, who holds it,
    // where the rotation resumes and how many edges have passed since it.
    int m_busy [4];
    int m_id   [4];
    int m_ptr  [4];
    int m_age  [4];
    int m_to   [4];

    task automatic m_grant(input int c, input int elig);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr[c] + k) % 4;
            if (((elig >> i) & 1) == 1) begin
                m_id[c]   = i;
                m_ptr[c]  = (i + 1) % 4;
                m_busy[c] = 1;
                m_age[c]  = 0;
                break;
            end
        end
    endtask

    task automatic model_step();
        int elig;
        elig = int'(req & req_mask);
        for (int c = 0; c < 4; c++) begin
            int b2b;
            int tmo;
            b2b = c % 2;
            tmo = (c >= 2) ? 4 : 0;
            if (rst) begin
                m_busy[c] = 0; m_id[c] = 0; m_ptr[c] = 0; m_age[c] = 0; m_to[c] = 0;
            end else begin
                m_to[c] = 0;
                if (m_busy[c] == 0) begin
                    if (elig != 0) m_grant(c, elig);
                end else if (ack) begin
                    if (b2b == 1 && elig != 0) m_grant(c, elig);
                    else m_busy[c] = 0;
                end else begin
                    m_age[c] = m_age[c] + 1;
                    if (tmo > 0 && m_age[c] == tmo) begin
                        m_busy[c] = 0;
                        m_to[c]   = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("vld[%0d]", c), 32'(gv[c]), 32'(m_busy[c]));
            chk($sformatf("id[%0d]", c), 32'(gid[c]), 32'(m_id[c]));
            chk($sformatf("oh[%0d]", c), 32'(goh[c]), (m_busy[c] != 0) ? (32'd1 << m_id[c]) : 32'd0);
            chk($sformatf("to[%0d]", c), 32'(tp[c]), 32'(m_to[c]));
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; req = 4'hF; req_mask = 4'hF; ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_busy[c] = 0; m_id[c] = 0; m_ptr[c] = 0; m_age[c] = 0; m_to[c] = 0;
        end

        // Reset state
        tick(); tick();
        for (int c = 0; c < 4; c++) begin
            chk("rst_vld", 32'(gv[c]), 32'd0);
            chk("rst_id", 32'(gid[c]), 32'd0);
        end

        // Full requests with ack held: B2B=0 idles between grants, B2B=1 rotates every edge
        rst = 1'b0; ack = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("seq_b2b0_vld", 32'(gv[0]), 32'(k % 2));
            if (k % 2 == 1) chk("seq_b2b0_id", 32'(gid[0]), 32'(((k - 1) / 2) % 4));
            chk("seq_b2b1_vld", 32'(gv[1]), 32'd1);
            chk("seq_b2b1_id", 32'(gid[1]), 32'((k - 1) % 4));
        end

        // Masked requests: only index 1 is ever granted
        rst = 1'b1; ack = 1'b0; tick();
        rst = 1'b0; req = 4'b1010; req_mask = 4'b0010;
        tick();
        chk("mask_first_id", 32'(gid[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            ack = (k % 2 == 1);
            tick();
            chk("mask_only1_a", 32'(gid[0]), 32'd1);
            chk("mask_only1_b", 32'(gid[1]), 32'd1);
        end
        ack = 1'b0; tick();
        chk("mask_busy_vld", 32'(gv[0]), 32'd1);
        req_mask = 4'hF;
        tick(); tick();
        chk("mask_hold_id", 32'(gid[0]), 32'd1);
        chk("mask_hold_vld", 32'(gv[0]), 32'd1);
        ack = 1'b1; tick();
        chk("mask_rel_vld", 32'(gv[0]), 32'd0);
        chk("mask_b2b_id", 32'(gid[1]), 32'd3);
        ack = 1'b0; tick();
        chk("mask_next_id", 32'(gid[0]), 32'd3);

        // Timeout: grant to id 2, no ack
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0100; req_mask = 4'hF;
        tick();
        chk("to_rise", 32'(gv[2]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_hold", 32'(gv[2]), 32'd1);
            chk("to_nopulse", 32'(tp[2]), 32'd0);
        end
        tick();
        chk("to_fall", 32'(gv[2]), 32'd0);
        chk("to_pulse", 32'(tp[2]), 32'd1);
        chk("to_id", 32'(gid[2]), 32'd2);
        chk("to0_holds", 32'(gv[0]), 32'd1);
        req = 4'h0; tick();
        chk("to_pulse_end", 32'(tp[2]), 32'd0);
        req = 4'hF; tick();
        chk("to_ptr_next", 32'(gid[2]), 32'd3);

        // Ack on the same edge the timeout would fire
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0100;
        tick(); tick(); tick(); tick();
        ack = 1'b1; tick();
        chk("ackto_vld", 32'(gv[2]), 32'd0);
        chk("ackto_pulse", 32'(tp[2]), 32'd0);
        ack = 1'b0;

        // Reset while busy on id 3
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b1000; tick();
        chk("rb_id", 32'(gid[0]), 32'd3);
        rst = 1'b1; req = 4'hF; ack = 1'b1; tick();
        for (int c = 0; c < 4; c++) begin
            chk("rb_vld", 32'(gv[c]), 32'd0);
            chk("rb_oh", 32'(goh[c]), 32'd0);
            chk("rb_id0", 32'(gid[c]), 32'd0);
            chk("rb_to", 32'(tp[c]), 32'd0);
        end
        rst = 1'b0; ack = 1'b0; tick();
        for (int c = 0; c < 4; c++) chk("rb_next", 32'(gid[c]), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            req      = 4'($urandom);
            req_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            ack      = ($urandom_range(0, 9) < 3);
            rst      = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
